// File: rtl/imul_pkg.sv
// Shared types and constants for the iterative 32-bit multiplier.
package imul_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } imul_state_t;

   localparam int IMUL_STEPS = 32;
   localparam int IMUL_CNT_W = 5;
   localparam logic [IMUL_CNT_W-1:0] IMUL_CNT_LAST = IMUL_CNT_W'(IMUL_STEPS - 1);
endpackage

// File: rtl/imul_if.sv
// Request/response val-rdy bundle between operand fetch, the multiplier and writeback.
interface imul_if;
   logic        req_val;
   logic        req_rdy;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [4:0]  req_waddr;
   logic        resp_val;
   logic        resp_rdy;
   logic [4:0]  resp_waddr;
   logic [31:0] resp_wdata;

   modport master (
      output req_val, req_a, req_b, req_waddr, resp_rdy,
      input  req_rdy, resp_val, resp_waddr, resp_wdata
   );

   modport slave (
      input  req_val, req_a, req_b, req_waddr, resp_rdy,
      output req_rdy, resp_val, resp_waddr, resp_wdata
   );
endinterface

// File: rtl/imul_dpath.sv
// Shift-add datapath: operand/accumulator/waddr registers and step counter.
// One multiplier bit retired per step; status bits feed the controlling FSM.
module imul_dpath
   import imul_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        step,
   input  logic [31:0] ld_a,
   input  logic [31:0] ld_b,
   input  logic [4:0]  ld_waddr,
   output logic [31:0] acc,
   output logic [4:0]  waddr,
   output logic        b_zero,
   output logic        cnt_last
);
   logic [31:0]           a;
   logic [31:0]           b;
   logic [IMUL_CNT_W-1:0] cnt;

   // Looks at b after this step's shift, so the exit decision is made on the same edge.
   assign b_zero   = (b[31:1] == 31'd0);
   assign cnt_last = (cnt == IMUL_CNT_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a     <= '0;
         b     <= '0;
         acc   <= '0;
         cnt   <= '0;
         waddr <= '0;
      end else if (load) begin
         a     <= ld_a;
         b     <= ld_b;
         waddr <= ld_waddr;
         acc   <= '0;
         cnt   <= '0;
      end else if (step) begin
         if (b[0])
            acc <= acc + a;
         a   <= a << 1;
         b   <= b >> 1;
         cnt <= cnt + IMUL_CNT_W'(1);
      end
   end
endmodule

// File: rtl/imul_unit.sv
// Iterative 32x32->32 multiplier, 32 CALC cycles (IMUL_EARLY_TERM_EN: stops once b runs out of ones).
// req_rdy only in IDLE, result held in DONE until resp_rdy; no combinational val/rdy paths.
module imul_unit
   import imul_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   imul_if.slave bus
);
`ifdef IMUL_EARLY_TERM_EN
   localparam bit EARLY_TERM = 1'b1;
`else
   localparam bit EARLY_TERM = 1'b0;
`endif

   imul_state_t state;
   logic        load;
   logic        step;
   logic        b_zero;
   logic        cnt_last;
   logic        calc_exit;

   assign load      = (state == IDLE) && bus.req_val;
   assign step      = (state == CALC);
   assign calc_exit = cnt_last || (EARLY_TERM && b_zero);

   imul_dpath u_dpath (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .step     (step),
      .ld_a     (bus.req_a),
      .ld_b     (bus.req_b),
      .ld_waddr (bus.req_waddr),
      .acc      (bus.resp_wdata),
      .waddr    (bus.resp_waddr),
      .b_zero   (b_zero),
      .cnt_last (cnt_last)
   );

   // req_rdy/resp_val are registered alongside state so they stay pure state decodes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         bus.req_rdy  <= 1'b1;
         bus.resp_val <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_val) begin
                  state       <= CALC;
                  bus.req_rdy <= 1'b0;
               end
            end
            CALC: begin
               if (calc_exit) begin
                  state        <= DONE;
                  bus.resp_val <= 1'b1;
               end
            end
            DONE: begin
               if (bus.resp_rdy) begin
                  state        <= IDLE;
                  bus.resp_val <= 1'b0;
                  bus.req_rdy  <= 1'b1;
               end
            end
            default: begin
               state        <= IDLE;
               bus.resp_val <= 1'b0;
               bus.req_rdy  <= 1'b1;
            end
         endcase
      end
   end
endmodule
